// File: rtl/pnm_pkg.sv
// Shared PNM definitions: write-back FSM states, page-mapping helpers and the
// default-parameter write-buffer entry layout used by both read and write sides.
package pnm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_e;

  function automatic int page_addr_bits(input int num_pages);
    return $clog2(num_pages);
  endfunction

  localparam int PNM_DATA_WIDTH     = 32;
  localparam int PNM_ADDRESS_SIZE   = 16;
  localparam int PNM_NUM_PAGES      = 64;
  localparam int PNM_PAGE_ADDR_BITS = page_addr_bits(PNM_NUM_PAGES);
  localparam int PNM_OFFSET_BITS    = PNM_ADDRESS_SIZE - PNM_PAGE_ADDR_BITS;

  // Page in the MSBs, page-local offset below it, then the data word.
  typedef struct packed {
    logic [PNM_PAGE_ADDR_BITS-1:0] page;
    logic [PNM_OFFSET_BITS-1:0]    offset;
    logic [PNM_DATA_WIDTH-1:0]     data;
  } pnm_wb_entry_t;

endpackage

// File: rtl/pnm_wb_fifo.sv
// Write-buffer FIFO for the result writer; registered-pointer design with no
// write-to-read bypass, so a pushed entry becomes visible the following cycle.
module pnm_wb_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_data    = r_mem[r_rptr[PW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pnm_result_writer.sv
// PNM write-back engine: buffers the compute result stream and writes each
// result into its owning page, in acceptance order, with per-page backpressure.
module pnm_result_writer
  import pnm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter int NUM_PAGES    = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              wb_start,
  input  logic [ADDRESS_SIZE-1:0]                           wb_count,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [ADDRESS_SIZE-1:0]                           in_addr,
  input  logic [DATA_WIDTH-1:0]                             in_data,
  input  logic [NUM_PAGES-1:0]                              page_ready,
  output logic [NUM_PAGES-1:0]                              wr_en,
  output logic [ADDRESS_SIZE-page_addr_bits(NUM_PAGES)-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]                             wr_data,
  output logic                                              busy,
  output logic                                              done
);

  localparam int PAGE_ADDR_BITS = page_addr_bits(NUM_PAGES);
  localparam int OFFSET_BITS    = ADDRESS_SIZE - PAGE_ADDR_BITS;

  typedef struct packed {
    logic [PAGE_ADDR_BITS-1:0] page;
    logic [OFFSET_BITS-1:0]    offset;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  wb_state_e               r_state;
  wb_state_e               w_state_nxt;
  logic [ADDRESS_SIZE-1:0] r_count;
  logic [ADDRESS_SIZE-1:0] r_accepted;
  logic [ADDRESS_SIZE-1:0] w_accepted_inc;
  logic [NUM_PAGES-1:0]    r_wr_en;
  logic [OFFSET_BITS-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_done;

  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_issue;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [ENTRY_W-1:0]      w_fifo_rdata;
  entry_t                  w_push_entry;
  entry_t                  w_head;
  logic [NUM_PAGES-1:0]    w_page_hit;

  assign w_push_entry.page   = in_addr[ADDRESS_SIZE-1 -: PAGE_ADDR_BITS];
  assign w_push_entry.offset = in_addr[OFFSET_BITS-1:0];
  assign w_push_entry.data   = in_data;

  assign w_push         = in_valid && w_in_ready;
  assign w_accepted_inc = r_accepted + 1'b1;

  pnm_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_issue),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head  = entry_t'(w_fifo_rdata);
  assign w_issue = !w_fifo_empty && page_ready[w_head.page];

  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page_dec
    assign w_page_hit[p] = (w_head.page == PAGE_ADDR_BITS'(p));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A zero-count job still passes through DRAIN (FIFO already empty),
        // so its done lands two cycles after the start pulse.
        if (wb_start) w_state_nxt = (wb_count == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        w_in_ready = !w_fifo_full;
        if (in_valid && w_in_ready && (w_accepted_inc == r_count)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_fifo_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_accepted <= '0;
    end else if (r_state == ST_IDLE && wb_start) begin
      r_count    <= wb_count;
      r_accepted <= '0;
    end else if (w_push) begin
      r_accepted <= w_accepted_inc;
    end
  end

  // Address/data hold their last value when nothing issues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_issue) begin
      r_wr_en   <= w_page_hit;
      r_wr_addr <= w_head.offset;
      r_wr_data <= w_head.data;
    end else begin
      r_wr_en   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (w_state_nxt == ST_DONE);
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule
